control_sequencer: RTL and testbench

- Multi-cycle control unit placed directly downstream of the instruction decoder in the model machine.
- Enables the decoder and consumes its one-hot instruction lines together with the Z/C flags.
- Sequences fetch, execute and jump-operand cycles.
- Drives the datapath strobes for the PC, IR, register file, ALU, I/O and memory read. Also counts retired instructions.

---
 rtl/control_sequencer.sv | 117 +++++++++++
 tb/tb_control_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/exec/jump sequencer driving datapath strobes.
// Strobes are Mealy outputs of the registered state and are forced low while rst is asserted.
module control_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             mem_ready,
  input  logic             movea,
  input  logic             moveb,
  input  logic             movec,
  input  logic             add,
  input  logic             sub,
  input  logic             and1,
  input  logic             not1,
  input  logic             rsr,
  input  logic             rsl,
  input  logic             jmp,
  input  logic             jz,
  input  logic             jc,
  input  logic             in1,
  input  logic             out1,
  input  logic             nop,
  input  logic             halt,
  input  logic             flag_z,
  input  logic             flag_c,
  output logic             dec_en,
  output logic             pc_oe,
  output logic             mem_rd,
  output logic             ir_ld,
  output logic             pc_inc,
  output logic             pc_ld,
  output logic             rf_we,
  output logic             alu_oe,
  output logic [2:0]       alu_op,
  output logic             flag_we,
  output logic             io_in_oe,
  output logic             io_out_ld,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_JUMP, S_HALT} state_t;
  state_t state_q, state_d;
  logic taken_q, taken_d, retire;
  logic [CNT_W-1:0] cnt_q;
  logic is_move, is_alu, is_jump;
  assign is_move = movea | moveb | movec;
  assign is_alu  = add | sub | and1 | not1 | rsr | rsl;
  assign is_jump = jmp | jz | jc;
  always_comb begin
    state_d   = state_q;
    taken_d   = taken_q;
    retire    = 1'b0;
    dec_en    = 1'b0;
    pc_oe     = 1'b0;
    mem_rd    = 1'b0;
    ir_ld     = 1'b0;
    pc_inc    = 1'b0;
    pc_ld     = 1'b0;
    rf_we     = 1'b0;
    alu_oe    = 1'b0;
    alu_op    = 3'd0;
    flag_we   = 1'b0;
    io_in_oe  = 1'b0;
    io_out_ld = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    if (rst) begin
      case (state_q)
        S_FETCH: begin
          pc_oe  = run;
          mem_rd = run;
          ir_ld  = run & mem_ready;
          pc_inc = run & mem_ready;
          state_d = (run & mem_ready) ? S_EXEC : S_FETCH;
        end
        S_EXEC: begin
          dec_en    = 1'b1;
          alu_oe    = is_move | is_alu;
          rf_we     = is_move | is_alu | in1;
          flag_we   = is_alu;
          io_in_oe  = in1;
          io_out_ld = out1;
          alu_op    = add ? 3'd0 : sub ? 3'd1 : and1 ? 3'd2 : not1 ? 3'd3 :
                      rsr ? 3'd4 : rsl ? 3'd5 : is_move ? 3'd6 : 3'd0;
          illegal   = ~(is_move | is_alu | is_jump | in1 | out1 | nop | halt);
          retire    = ~is_jump;
          taken_d   = is_jump ? (jmp | (jz & flag_z) | (jc & flag_c)) : taken_q;
          state_d   = is_jump ? S_JUMP : halt ? S_HALT : S_FETCH;
        end
        S_JUMP: begin
          pc_oe   = 1'b1;
          mem_rd  = 1'b1;
          pc_ld   = mem_ready & taken_q;
          pc_inc  = mem_ready & ~taken_q;
          retire  = mem_ready;
          state_d = mem_ready ? S_FETCH : S_JUMP;
        end
        default: halted = 1'b1;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      taken_q <= taken_d;
      if (retire && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random instruction streams scored against an instruction-level model.
// A second instance with a 2-bit counter exercises saturation alongside the 16-bit one.
module tb_control_sequencer;
  logic clk = 1'b0;
  logic rst, run, mem_ready, flag_z, flag_c;
  logic [15:0] lines;
  wire [15:0] o1, o2;
  wire [15:0] cnt1;
  wire [1:0] cnt2;
  typedef struct packed {
    logic [15:0] s;
    logic [15:0] c;
    logic [1:0]  c2;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  control_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .mem_ready(mem_ready),
    .movea(lines[0]), .moveb(lines[1]), .movec(lines[2]), .add(lines[3]),
    .sub(lines[4]), .and1(lines[5]), .not1(lines[6]), .rsr(lines[7]),
    .rsl(lines[8]), .jmp(lines[9]), .jz(lines[10]), .jc(lines[11]),
    .in1(lines[12]), .out1(lines[13]), .nop(lines[14]), .halt(lines[15]),
    .flag_z(flag_z), .flag_c(flag_c),
    .dec_en(o1[15]), .pc_oe(o1[14]), .mem_rd(o1[13]), .ir_ld(o1[12]),
    .pc_inc(o1[11]), .pc_ld(o1[10]), .rf_we(o1[9]), .alu_oe(o1[8]),
    .alu_op(o1[7:5]), .flag_we(o1[4]), .io_in_oe(o1[3]), .io_out_ld(o1[2]),
    .halted(o1[1]), .illegal(o1[0]), .instr_count(cnt1)
  );
  control_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .run(run), .mem_ready(mem_ready),
    .movea(lines[0]), .moveb(lines[1]), .movec(lines[2]), .add(lines[3]),
    .sub(lines[4]), .and1(lines[5]), .not1(lines[6]), .rsr(lines[7]),
    .rsl(lines[8]), .jmp(lines[9]), .jz(lines[10]), .jc(lines[11]),
    .in1(lines[12]), .out1(lines[13]), .nop(lines[14]), .halt(lines[15]),
    .flag_z(flag_z), .flag_c(flag_c),
    .dec_en(o2[15]), .pc_oe(o2[14]), .mem_rd(o2[13]), .ir_ld(o2[12]),
    .pc_inc(o2[11]), .pc_ld(o2[10]), .rf_we(o2[9]), .alu_oe(o2[8]),
    .alu_op(o2[7:5]), .flag_we(o2[4]), .io_in_oe(o2[3]), .io_out_ld(o2[2]),
    .halted(o2[1]), .illegal(o2[0]), .instr_count(cnt2)
  );
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (o1 !== e.s || cnt1 !== e.c) begin
        miscompares++;
        $display("FAIL cnt16 t=%0t: strobes=%h count=%0d, required strobes=%h count=%0d",
                 $time, o1, cnt1, e.s, e.c);
      end
      vectors++;
      if (o2 !== e.s || cnt2 !== e.c2) begin
        miscompares++;
        $display("FAIL cnt2 t=%0t: strobes=%h count=%0d, required strobes=%h count=%0d",
                 $time, o2, cnt2, e.s, e.c2);
      end
    end
  end
  // Model: instruction ops 0..15 follow the decoder line order, 16 means no line set.
  initial begin
    int phase, op, cnt, hcnt;
    logic taken, ret;
    exp_t ex;
    phase = 0; cnt = 0; hcnt = 0; taken = 1'b0;
    rst = 1'b0; run = 1'b0; mem_ready = 1'b0; flag_z = 1'b0; flag_c = 1'b0; lines = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      op = int'($urandom_range(0, 16));
      if (op == 15 && $urandom_range(0, 3) != 0) op = 14;
      run       = ($urandom_range(0, 5) != 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      flag_z    = 1'($urandom);
      flag_c    = 1'($urandom);
      lines     = (op < 16) ? (16'd1 << op) : 16'd0;
      rst       = !(cyc < 2 || (phase == 3 && hcnt > 4) || $urandom_range(0, 99) == 0);
      ex.s = '0;
      ret  = 1'b0;
      if (!rst) begin
        phase = 0;
        cnt   = 0;
      end else begin
        case (phase)
          0: if (run) begin
            ex.s[14] = 1'b1; ex.s[13] = 1'b1;
            if (mem_ready) begin ex.s[12] = 1'b1; ex.s[11] = 1'b1; phase = 1; end
          end
          1: begin
            ex.s[15] = 1'b1; ret = 1'b1; phase = 0;
            if (op <= 2) begin
              ex.s[8] = 1'b1; ex.s[9] = 1'b1; ex.s[7:5] = 3'd6;
            end else if (op <= 8) begin
              ex.s[8] = 1'b1; ex.s[9] = 1'b1; ex.s[4] = 1'b1; ex.s[7:5] = 3'(op - 3);
            end else if (op <= 11) begin
              ret = 1'b0; phase = 2;
              taken = (op == 9) || (op == 10 && flag_z) || (op == 11 && flag_c);
            end else if (op == 12) begin
              ex.s[3] = 1'b1; ex.s[9] = 1'b1;
            end else if (op == 13) ex.s[2] = 1'b1;
            else if (op == 15) phase = 3;
            else if (op == 16) ex.s[0] = 1'b1;
          end
          2: begin
            ex.s[14] = 1'b1; ex.s[13] = 1'b1;
            if (mem_ready) begin
              if (taken) ex.s[10] = 1'b1; else ex.s[11] = 1'b1;
              ret = 1'b1; phase = 0;
            end
          end
          default: ex.s[1] = 1'b1;
        endcase
      end
      ex.c  = 16'(cnt);
      ex.c2 = (cnt > 3) ? 2'd3 : 2'(cnt);
      q.push_back(ex);
      if (ret && cnt < 65535) cnt++;
      hcnt = (phase == 3) ? hcnt + 1 : 0;
    end
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
